// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage.
// Extracts load lanes, drives the register file write port and bypasses WB to ID.
module mem_wb_stage #(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    input  logic                m_valid,
    input  logic                m_regwrite,
    input  logic                m_memtoreg,
    input  logic [1:0]          m_ld_size,
    input  logic                m_ld_unsigned,
    input  logic [1:0]          m_addr_lo,
    input  logic [31:0]         m_alu_result,
    input  logic [31:0]         m_read_data,
    input  logic [4:0]          m_wa,
    output logic                we3,
    output logic [4:0]          wa3,
    output logic [31:0]         wd3,
    input  logic [4:0]          ra1,
    input  logic [4:0]          ra2,
    input  logic [31:0]         rf_rd1,
    input  logic [31:0]         rf_rd2,
    output logic [31:0]         byp_rd1,
    output logic [31:0]         byp_rd2,
    output logic                misaligned,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [RETIRE_W-1:0] RET_ONE = 1;

    logic                valid_q;
    logic                regwrite_q;
    logic                mis_q;
    logic [4:0]          wa_q;
    logic [31:0]         wd_q;
    logic [RETIRE_W-1:0] retired_q;

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] res_d;
    logic        mis_d;

    always_comb begin
        byte_sel = m_read_data[7:0];
        unique case (m_addr_lo)
            2'd0: byte_sel = m_read_data[7:0];
            2'd1: byte_sel = m_read_data[15:8];
            2'd2: byte_sel = m_read_data[23:16];
            2'd3: byte_sel = m_read_data[31:24];
        endcase
        half_sel = m_addr_lo[1] ? m_read_data[31:16] : m_read_data[15:0];
    end

    always_comb begin
        res_d = m_alu_result;
        mis_d = 1'b0;
        if (m_memtoreg) begin
            unique case (m_ld_size)
                2'b01: res_d = {{24{~m_ld_unsigned & byte_sel[7]}}, byte_sel};
                2'b10: begin
                    res_d = {{16{~m_ld_unsigned & half_sel[15]}}, half_sel};
                    mis_d = m_addr_lo[0];
                end
                default: begin
                    // Reserved size 11 behaves as a word load
                    res_d = m_read_data;
                    mis_d = (m_addr_lo != 2'b00);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            mis_q      <= 1'b0;
            wa_q       <= 5'd0;
            wd_q       <= 32'd0;
            retired_q  <= '0;
        end else begin
            if (valid_q && !stall) begin
                retired_q <= retired_q + RET_ONE;
            end
            if (flush) begin
                valid_q <= 1'b0;
            end else if (!stall) begin
                valid_q    <= m_valid;
                regwrite_q <= m_regwrite;
                mis_q      <= mis_d;
                wa_q       <= m_wa;
                wd_q       <= res_d;
            end
        end
    end

    assign we3        = valid_q & regwrite_q & (wa_q != 5'd0) & ~mis_q;
    assign wa3        = wa_q;
    assign wd3        = wd_q;
    assign misaligned = valid_q & mis_q;
    assign retired    = retired_q;

    // The register file returns stale data for a same-cycle write
    assign byp_rd1 = (we3 && wa3 == ra1) ? wd3 : rf_rd1;
    assign byp_rd2 = (we3 && wa3 == ra2) ? wd3 : rf_rd2;

endmodule
